sigma_delta_dac_mc: RTL
=======================

// Module: sigma_delta_dac_mc
// PURPOSE
//  Multi-channel, selectable 1st/2nd-order sigma-delta DAC; successor to the single-channel 1st-order audio DAC.
//  Audio front-end pushes sample frames into a small FIFO via valid/ready; a sample-rate strobe (UPDATE) loads the next frame.
//  Each channel drives a 1-bit pin into an external analog low-pass filter. Underrun is flagged sticky.
// PARAMETERS
//  MSBI      7  MSB index of a channel sample; sample width N = MSBI+1
//  NCH       2  number of channels (1..8)
//  ORDER     1  modulator order, 1 or 2 (any other value is illegal)
//  SIGNED_IN 0  0: offset binary (excess 2**MSBI); 1: two's complement, converted by inverting the MSB
//  DEPTH     4  FIFO depth in frames, power of 2, >= 2
// PORTS
//  CLK          in   1               system clock, all logic on rising edge
//  RESET_N      in   1               asynchronous active-low reset
//  CEN          in   1               modulator clock enable; integrators and DACout advance only when 1
//  IN_DATA      in   NCH*N           frame; channel k = IN_DATA[k*N +: N]
//  IN_VALID     in   1               frame valid
//  IN_READY     out  1               FIFO can accept a frame
//  UPDATE       in   1               sample-rate strobe: pop one frame into the active registers
//  UNDERRUN     out  1               sticky: UPDATE seen while FIFO empty
//  UNDERRUN_CLR in   1               clears UNDERRUN
//  FIFO_LEVEL   out  $clog2(DEPTH)+1 frames currently held
//  DACout       out  NCH             per-channel 1-bit modulator output, registered
// BEHAVIOUR
//  Reset (async, while RESET_N=0): FIFO empty, FIFO_LEVEL=0, IN_READY=0 during reset then 1 after release,
//   UNDERRUN=0, DACout=0, all integrators=0, active sample per channel = 2**MSBI (midscale, offset binary).
//   Reset asserted mid-operation clears all state immediately. Frames in flight are lost.
//  FIFO: IN_READY = !full. Push when IN_VALID&IN_READY. No bypass: a frame pushed in cycle t is poppable from t+1.
//   UPDATE with level>0: pop; active registers take the frame on the same edge, so the modulator uses it from the next CEN cycle.
//   UPDATE with level==0: no pop, active registers hold, UNDERRUN<=1.
//   Push and pop in the same cycle: level unchanged. Full FIFO plus UPDATE: pop only (IN_READY was 0).
//   UNDERRUN set and clear in the same cycle: set wins. FIFO and UPDATE logic ignore CEN.
//  Input conversion: x = SIGNED_IN ? {~d[MSBI], d[MSBI-1:0]} : d, giving unsigned x in [0, 2**N-1].
//  ORDER=1, per channel, N+2-bit latch L:
//   delta = x + ({L[N+1],L[N+1]} << N); sigma = delta + L (mod 2**(N+2));
//   on CEN: L<=sigma, DACout<=L[N+1]. Bit-exact with the previous single-channel DAC.
//  ORDER=2, per channel, signed N+4-bit integrators i1, i2; fb = DACout ? 2**N : 0:
//   on CEN: i1<=i1+x-fb; i2<=i2+(i1+x-fb)-fb; DACout<=(i2_next >= 0).
//   Saturate i1 and i2 at the N+4-bit signed limits; no wrap.
//  Output ones density over long windows = x/2**N, both orders.
//  CEN=0: DACout, L, i1 and i2 hold. Channels are fully independent apart from the shared FIFO/UPDATE.
//  Latency: UPDATE edge to first DACout bit reflecting the new sample: ORDER=1, 2 CEN cycles; ORDER=2, 1 CEN cycle.
// TESTING
//  1. Reset, then idle with CEN=1, no UPDATE -> every DACout has exactly 128 ones in any 256-cycle window after settling
//     (ORDER=1, MSBI=7). Assert RESET_N mid-run -> DACout=0 immediately.
//  2. ORDER=1, ch0 x=0x40, ch1 x=0xC0, CEN=1 -> ones in 256 cycles: 64 and 192, ±1.
//     Bit stream matches a golden model of the previous single-channel DAC.
//  3. DEPTH=4: push 5 frames, no UPDATE -> IN_READY=0 after the 4th, FIFO_LEVEL=4.
//     Push with UPDATE while full -> level 3. Simultaneous push+pop at level 2 -> stays 2.
//  4. UPDATE with FIFO empty -> UNDERRUN=1, active sample unchanged.
//     UNDERRUN_CLR together with a second empty UPDATE -> UNDERRUN stays 1. CLR alone -> 0.
//  5. SIGNED_IN=1, ORDER=2: input 0x80 (-128) -> DACout all 0 after settling; 0x7F -> ones density 255/256 ±1%;
//     full-scale steps -> no integrator wrap (saturation asserted).
//  6. CEN pulsed 1-in-4 -> DACout changes only on edges with CEN=1; stream equals the CEN=1 stream decimated.

Source files
------------

// File: rtl/sigma_delta_dac_mc_if.sv
// Frame push / sample-rate / status bundle between an audio front-end and the
// multi-channel sigma-delta DAC.
interface sigma_delta_dac_mc_if #(
    parameter int MSBI  = 7,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
);
    localparam int N  = MSBI + 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic                CEN;
    logic [NCH*N-1:0]    IN_DATA;
    logic                IN_VALID;
    logic                IN_READY;
    logic                UPDATE;
    logic                UNDERRUN;
    logic                UNDERRUN_CLR;
    logic [LW-1:0]       FIFO_LEVEL;
    logic [NCH-1:0]      DACout;

    modport master (
        output CEN, IN_DATA, IN_VALID, UPDATE, UNDERRUN_CLR,
        input  IN_READY, UNDERRUN, FIFO_LEVEL, DACout
    );

    modport slave (
        input  CEN, IN_DATA, IN_VALID, UPDATE, UNDERRUN_CLR,
        output IN_READY, UNDERRUN, FIFO_LEVEL, DACout
    );
endinterface

// File: rtl/sigma_delta_dac_mc.sv
// Multi-channel 1st/2nd-order sigma-delta DAC fed by a small frame FIFO that is
// drained one frame per sample-rate UPDATE strobe.
module sigma_delta_dac_mc #(
    parameter int MSBI      = 7,
    parameter int NCH       = 2,
    parameter int ORDER     = 1,
    parameter int SIGNED_IN = 0,
    parameter int DEPTH     = 4
) (
    input logic                  CLK,
    input logic                  RESET_N,
    sigma_delta_dac_mc_if.slave  bus
);
    localparam int N  = MSBI + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = N + 4;
    localparam int SW = N + 6;

    localparam logic signed [SW-1:0] IMAX = SW'((1 <<< (IW - 1)) - 1);
    localparam logic signed [SW-1:0] IMIN = SW'(-(1 <<< (IW - 1)));
    localparam logic signed [SW-1:0] FS   = SW'(1 <<< N);

    function automatic logic [N-1:0] to_offset(input logic [N-1:0] d);
        to_offset = (SIGNED_IN != 0) ? {~d[N-1], d[N-2:0]} : d;
    endfunction

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > IMAX)      sat = IMAX[IW-1:0];
        else if (v < IMIN) sat = IMIN[IW-1:0];
        else               sat = v[IW-1:0];
    endfunction

    logic [NCH*N-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q, level_d;
    logic             ready_q;
    logic             underrun_q, underrun_d;
    logic             push, pop;
    logic [N-1:0]     act_q [NCH];
    logic [NCH-1:0]   dac_q, dac_d;

    // Stage: frame FIFO and sample-rate load (independent of CEN)
    assign push = bus.IN_VALID & ready_q;
    assign pop  = bus.UPDATE & (level_q != '0);

    always_comb begin
        level_d = level_q;
        if (push && !pop)      level_d = level_q + 1'b1;
        else if (pop && !push) level_d = level_q - 1'b1;
    end

    always_comb begin
        underrun_d = underrun_q;
        if (bus.UNDERRUN_CLR)                 underrun_d = 1'b0;
        if (bus.UPDATE && (level_q == '0))    underrun_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= bus.IN_DATA;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            for (int k = 0; k < NCH; k++) act_q[k] <= {1'b1, {MSBI{1'b0}}};
        end else begin
            level_q    <= level_d;
            ready_q    <= (level_d != LW'(DEPTH));
            underrun_q <= underrun_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                for (int k = 0; k < NCH; k++)
                    act_q[k] <= to_offset(mem_q[rd_ptr_q][k*N +: N]);
            end
        end
    end

    // Stage: per-channel modulator (advances only on CEN)
    for (genvar k = 0; k < NCH; k++) begin : g_ch
        if (ORDER == 2) begin : g_o2
            logic signed [IW-1:0] i1_q, i2_q, i1_d, i2_d;
            logic signed [SW-1:0] x_s, fb_s;

            always_comb begin
                x_s  = $signed({{(SW-N){1'b0}}, act_q[k]});
                fb_s = dac_q[k] ? FS : '0;
                i1_d = sat(SW'(i1_q) + x_s - fb_s);
                i2_d = sat(SW'(i2_q) + SW'(i1_d) - fb_s);
            end

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    i1_q <= '0;
                    i2_q <= '0;
                end else if (bus.CEN) begin
                    i1_q <= i1_d;
                    i2_q <= i2_d;
                end
            end

            assign dac_d[k] = ~i2_d[IW-1];
        end else begin : g_o1
            // Legacy latch arithmetic: the top bit of L is both output and feedback.
            logic [N+1:0] l_q, sigma;

            always_comb begin
                sigma = {2'b00, act_q[k]} + {l_q[N+1], l_q[N+1], {N{1'b0}}} + l_q;
            end

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N)     l_q <= '0;
                else if (bus.CEN) l_q <= sigma;
            end

            assign dac_d[k] = l_q[N+1];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)     dac_q <= '0;
        else if (bus.CEN) dac_q <= dac_d;
    end

    assign bus.IN_READY   = ready_q;
    assign bus.UNDERRUN   = underrun_q;
    assign bus.FIFO_LEVEL = level_q;
    assign bus.DACout     = dac_q;
endmodule
